// File: rtl/mem_access_ctl.sv
// Data-memory access controller: decodes MEM-stage loads/stores, runs a
// request/grant/rvalid handshake with timeout, and extends load results.
module mem_access_ctl #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_rd_mac_i,
    input  logic        mem_wr_mac_i,
    input  logic [2:0]  funct3_mac_i,
    input  logic [31:0] addr_mac_i,
    input  logic [31:0] wdata_mac_i,
    output logic        dmem_req_mac_o,
    output logic        dmem_we_mac_o,
    output logic [3:0]  dmem_be_mac_o,
    output logic [31:0] dmem_addr_mac_o,
    output logic [31:0] dmem_wdata_mac_o,
    input  logic        dmem_gnt_mac_i,
    input  logic        dmem_rvalid_mac_i,
    input  logic [31:0] dmem_rdata_mac_i,
    output logic [31:0] rdata_mac_o,
    output logic        stall_mac_o,
    output logic        misalign_mac_o,
    output logic        bus_err_mac_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [2:0]    funct3_q, funct3_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          bus_err_q, bus_err_d;

    logic        legal, access_valid, aligned, timeout;
    logic [3:0]  be_new;
    logic [31:0] wdata_new, rsh, load_ext;

    // Decode of the incoming MEM-stage access; rd&wr together is a store.
    always_comb begin
        legal     = 1'b0;
        aligned   = 1'b1;
        be_new    = 4'b1111;
        wdata_new = wdata_mac_i;
        if (mem_wr_mac_i) begin
            legal = (funct3_mac_i == 3'b000) || (funct3_mac_i == 3'b001) ||
                    (funct3_mac_i == 3'b010);
        end else if (mem_rd_mac_i) begin
            legal = (funct3_mac_i == 3'b000) || (funct3_mac_i == 3'b001) ||
                    (funct3_mac_i == 3'b010) || (funct3_mac_i == 3'b100) ||
                    (funct3_mac_i == 3'b101);
        end
        case (funct3_mac_i[1:0])
            2'b00: begin
                be_new    = 4'b0001 << addr_mac_i[1:0];
                wdata_new = {4{wdata_mac_i[7:0]}};
            end
            2'b01: begin
                aligned   = ~addr_mac_i[0];
                be_new    = 4'b0011 << {addr_mac_i[1], 1'b0};
                wdata_new = {2{wdata_mac_i[15:0]}};
            end
            default: aligned = (addr_mac_i[1:0] == 2'b00);
        endcase
        access_valid = (mem_rd_mac_i | mem_wr_mac_i) & legal;
    end

    always_comb begin
        rsh = dmem_rdata_mac_i >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{24{rsh[7]}}, rsh[7:0]};
            3'b001:  load_ext = {{16{rsh[15]}}, rsh[15:0]};
            3'b100:  load_ext = {24'b0, rsh[7:0]};
            3'b101:  load_ext = {16'b0, rsh[15:0]};
            default: load_ext = dmem_rdata_mac_i;
        endcase
    end

    // Budget covers REQ and WAIT together, so compare with >= after a late grant.
    assign timeout = (cnt_q >= TO_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        addr_d    = addr_q;
        funct3_d  = funct3_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = '0;
        bus_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access_valid && aligned) begin
                    state_d  = S_REQ;
                    addr_d   = addr_mac_i;
                    funct3_d = funct3_mac_i;
                    we_d     = mem_wr_mac_i;
                    be_d     = be_new;
                    wdata_d  = wdata_new;
                end
            end
            S_REQ: begin
                if (dmem_gnt_mac_i) begin
                    state_d = we_q ? S_DONE : S_WAIT;
                    cnt_d   = cnt_q + 1'b1;
                end else if (timeout) begin
                    state_d   = S_DONE;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (dmem_rvalid_mac_i) begin
                    state_d = S_DONE;
                    rdata_d = load_ext;
                end else if (timeout) begin
                    state_d   = S_DONE;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            funct3_q  <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            funct3_q  <= funct3_d;
            we_q      <= we_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Bus outputs are driven only while requesting; IDLE terms are gated by reset.
    assign dmem_req_mac_o   = (state_q == S_REQ);
    assign dmem_we_mac_o    = dmem_req_mac_o & we_q;
    assign dmem_be_mac_o    = dmem_req_mac_o ? be_q : '0;
    assign dmem_addr_mac_o  = dmem_req_mac_o ? {addr_q[31:2], 2'b00} : '0;
    assign dmem_wdata_mac_o = dmem_req_mac_o ? wdata_q : '0;
    assign rdata_mac_o      = (state_q == S_DONE) ? rdata_q : '0;
    assign bus_err_mac_o    = bus_err_q;
    assign misalign_mac_o   = ~reset & (state_q == S_IDLE) & access_valid & ~aligned;
    assign stall_mac_o      = (~reset & (state_q == S_IDLE) & access_valid & aligned) |
                              (state_q == S_REQ) | (state_q == S_WAIT);

endmodule

// File: doc/mem_access_ctl.md
MEM_ACCESS_CTL -- requirements
Module: mem_access_ctl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16, SHALL set the cycle limit for one outstanding data-memory transaction before abort.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 mem_rd_mac_i  input  1  SHALL flag a load in the MEM stage.
REQ-005 mem_wr_mac_i  input  1  SHALL flag a store in the MEM stage.
REQ-006 funct3_mac_i  input  3  SHALL carry the load/store funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-007 addr_mac_i  input  32  SHALL carry the byte address from the ALU.
REQ-008 wdata_mac_i  input  32  SHALL carry the store data (rs2).
REQ-009 dmem_req_mac_o  output  1  SHALL be the memory request strobe.
REQ-010 dmem_we_mac_o  output  1  SHALL be the write enable (1 = store).
REQ-011 dmem_be_mac_o  output  4  SHALL carry the byte-lane enables.
REQ-012 dmem_addr_mac_o  output  32  SHALL carry the word-aligned address ({addr[31:2],2'b00}).
REQ-013 dmem_wdata_mac_o  output  32  SHALL carry lane-replicated store data.
REQ-014 dmem_gnt_mac_i  input  1  SHALL be the memory grant (request accepted).
REQ-015 dmem_rvalid_mac_i / dmem_rdata_mac_i  input  1/32  SHALL be the read-data valid and the read data.
REQ-016 rdata_mac_o  output  32  SHALL carry the extended load result.
REQ-017 stall_mac_o  output  1  SHALL hold the pipeline while an access is in progress.
REQ-018 misalign_mac_o / bus_err_mac_o  output  1/1  SHALL each give a one-cycle exception pulse.

Function
REQ-019 The FSM SHALL have the states IDLE, REQ, WAIT and DONE.
REQ-020 Access valid SHALL be defined as (rd|wr) with a legal funct3; when rd and wr are both set, the access SHALL be treated as a store.
REQ-021 Illegal funct3 values (load 011/110/111, store 011-111) SHALL produce no request, no stall and no pulse.
REQ-022 Alignment SHALL require word: addr[1:0]=00; half: addr[0]=0; byte: always aligned.
REQ-023 In IDLE, a valid misaligned access SHALL pulse misalign_mac_o for 1 cycle, issue no request, keep stall low and stay in IDLE.
REQ-024 In IDLE, a valid aligned access SHALL register addr, funct3, we, be and wdata, drive stall_mac_o high combinationally in the same cycle, and move to REQ.
REQ-025 In REQ, the block SHALL assert dmem_req_mac_o and hold addr, we, be and wdata stable until dmem_gnt_mac_i=1.
REQ-026 On grant in REQ, a store SHALL go to DONE and a load SHALL go to WAIT; req SHALL drop in the cycle after the grant.
REQ-027 In WAIT, the block SHALL capture rdata on dmem_rvalid_mac_i=1, extend it per REQ-029, and go to DONE.
REQ-028 In DONE, stall_mac_o SHALL be 0, rdata_mac_o SHALL be valid for exactly that cycle, inputs SHALL be ignored, and the next state SHALL be IDLE.
REQ-029 Load extension SHALL select the lane by addr[1:0] (byte) or addr[1] (half); LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, and LW SHALL pass the data through.
REQ-030 Byte enables SHALL be SB: 0001<<addr[1:0]; SH: 0011<<{addr[1],1'b0}; SW: 1111; loads SHALL use the same enables.
REQ-031 Store data SHALL be replicated to lanes: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
REQ-032 A wait counter SHALL clear on entry to REQ and increment each cycle in REQ/WAIT.
REQ-033 When the wait counter reaches TIMEOUT_CYC-1 without the expected gnt/rvalid, the block SHALL pulse bus_err_mac_o, drop req, force rdata_mac_o=0 and go to DONE.
REQ-034 A gnt in the same cycle as the timeout SHALL win; an rvalid outside WAIT SHALL be ignored.
REQ-035 Stall SHALL equal (IDLE & valid & aligned) | REQ | WAIT.

Reset
REQ-036 While reset is asserted, the FSM SHALL be in IDLE, the counter and all registers SHALL be 0, and every output SHALL be 0.
REQ-037 Reset asserted mid-transaction SHALL abort it immediately with no exception pulse; req SHALL drop asynchronously.
REQ-038 The first request after reset deassertion SHALL be accepted on the first rising clock edge.

Verification
REQ-039 SW addr=0x100, data=0xDEADBEEF, gnt after 2 cycles -> be=1111, addr=0x100, stall high 3 cycles + DONE low, req drops after gnt.
REQ-040 LB addr=0x203, rdata=0x80FF_FF7F, gnt 1 cycle, rvalid 1 cycle later -> be=1000, rdata_mac_o=0xFFFFFF80; LBU -> 0x00000080.
REQ-041 SH addr=0x302, wdata=0x1234ABCD -> be=1100, dmem_wdata=0xABCDABCD; LH addr=0x301 -> misalign pulse, no req, no stall.
REQ-042 LW with gnt never asserted, TIMEOUT_CYC=16 -> bus_err pulse 16 cycles after REQ entry, rdata_mac_o=0, back to IDLE.
REQ-043 Reset asserted in WAIT -> req=0 and stall=0 immediately, no pulse; next LW completes normally.
REQ-044 rd=wr=1, funct3=010 -> store issued (we=1); funct3=111 with rd=1 -> no request, no stall.
